cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
Instruction-cycle controller for the 8-bit Von Neumann CPU. It runs the Fetch/Decode/Execute phases and decodes the instruction register value. It drives every load strobe and select line consumed by the PC block, the instruction and immediate registers, the result mux, the register file and the ALU. It sits directly upstream of the PC block and is the sole source of its pcload/pcsel/addrsel controls.

Parameters:
ILLEGAL_HALTS, 0, 1: opcodes 0xC-0xE enter HALT; 0: they execute as NOP.

Ports:
clk  input  1  system clock, all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
irvalue  input  8  instruction register; [7:4] opcode, [3:2] dreg, [1:0] sreg
zero  input  1  register-file flag: selected dest register == 0
negative  input  1  register-file flag: selected dest register bit 7
irload  output  1  instruction register load enable
imload  output  1  immediate register load enable
pcload  output  1  PC register load enable
pcsel  output  1  PC input select; 0 = PC+1, 1 = imm
addrsel  output  2  address mux; 0 = pcout, 1 = imm, 2 = sbus, 3 = dbus
regsel  output  2  result mux; 0 = imm, 1 = sbus, 2 = datain, 3 = aluout
dwrite  output  1  register-file write enable
dregsel  output  2  destination register select (= irvalue[3:2])
sregsel  output  2  source register select (= irvalue[1:0])
aluop  output  2  ALU operation (= opcode-1 for ADD/SUB/AND/OR, else 0)
halted  output  1  high while in HALT
phase  output  3  current state encoding, debug only

Behaviour:
- Opcodes: 0 NOP; 1 ADD, 2 SUB, 3 AND, 4 OR (Rd <= Rd op Rs, regsel 3); 5 MOV (Rd <= Rs, regsel 1); 6 LDI (two-byte, Rd <= imm, regsel 0); 7 LD (Rd <= mem[Rs], addrsel 2, regsel 2); 9 JMP (two-byte, PC <= imm); A JZ, B JN (two-byte, PC <= imm if zero/negative); F HALT; 8, C-E illegal. Opcode 8 is reserved for a future store and is always NOP regardless of ILLEGAL_HALTS.
- States: RST, FETCH, DECODE, IMM, EXEC, HALT. Outputs are Moore, decoded combinationally from state and irvalue.
- While rst_n=0, state is RST. All strobes (irload, imload, pcload, dwrite) are 0, and pcsel, addrsel, regsel, aluop and halted are 0. The first edge after release moves to FETCH. Reset asserted at any point aborts the instruction without completing a write.
- FETCH: addrsel=0, irload=1, pcload=1, pcsel=0. Next state is DECODE.
- DECODE: no strobes. Two-byte opcodes go to IMM, HALT goes to HALT, and all others go to EXEC.
- IMM: addrsel=0, imload=1, pcload=1, pcsel=0. Next state is EXEC.
- EXEC: ALU/MOV/LDI/LD assert dwrite=1 with the listed regsel and addrsel. JMP asserts pcload=1, pcsel=1. JZ/JN assert pcload=1, pcsel=1 only if the flag is 1 during EXEC; otherwise there are no strobes. NOP has no strobes. Next state is FETCH.
- HALT: halted=1, all strobes 0. The block remains in HALT until reset.
- Latency: one-byte instructions take 3 clocks from FETCH to FETCH; two-byte instructions take 4.
- dregsel and sregsel follow irvalue in all states except RST, where they are 0.
- Strobes are never asserted simultaneously with conflicting selects. At most one of irload and imload is asserted per cycle. dwrite and pcload=1 with pcsel=1 are never asserted together.
- PC wrap from 0xFF to 0x00 is the PC block's concern. The sequencer is unaffected; after reset, PC reads 0xFF, so the first fetch is from address 0xFF.

Decomposition:
- Shared package cpu_pkg: opcode localparams, state encoding, and the addrsel, regsel and pcsel code constants, so the PC block and the mux users agree on the same codes.
- One sub-module, instr_decoder, is combinational. It maps opcode to is_two_byte, is_alu, is_branch, is_halt and is_illegal, plus the default regsel and aluop.

Test Plan:
- Hold rst_n=0 for 3 clocks, then release: all outputs 0 during reset; FETCH asserts irload=1, pcload=1, addrsel=0 on the first cycle after release.
- irvalue=0x16 (ADD R1,R2): EXEC asserts dwrite=1, regsel=3, aluop=0, dregsel=1, sregsel=2; the next FETCH follows exactly 3 clocks after the previous one.
- irvalue=0x6C (LDI R3): IMM asserts imload=1, pcload=1; EXEC asserts dwrite=1, regsel=0; 4-clock cycle.
- irvalue=0xA0 (JZ) with zero=1: EXEC asserts pcload=1, pcsel=1. With zero=0: no strobes in EXEC.
- irvalue=0xF0: after DECODE, halted=1 and no strobes for 20 clocks; rst_n pulse returns the block to RST and then FETCH.
- irvalue=0xD0: with ILLEGAL_HALTS=0 it executes as NOP with no strobes in EXEC; with ILLEGAL_HALTS=1 halted=1. Reset asserted mid-EXEC of 0x16: dwrite drops to 0 immediately, asynchronously.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared codes for the 8-bit CPU: opcodes, sequencer state encoding and the
// select-line values agreed between the sequencer, the PC block and the muxes.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_MOV  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_ST   = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_JN   = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ST_RST    = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_IMM    = 3'd3;
  localparam logic [2:0] ST_EXEC   = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  localparam logic [1:0] ADDR_PC   = 2'd0;
  localparam logic [1:0] ADDR_IMM  = 2'd1;
  localparam logic [1:0] ADDR_SBUS = 2'd2;
  localparam logic [1:0] ADDR_DBUS = 2'd3;

  localparam logic [1:0] REG_IMM    = 2'd0;
  localparam logic [1:0] REG_SBUS   = 2'd1;
  localparam logic [1:0] REG_DATAIN = 2'd2;
  localparam logic [1:0] REG_ALU    = 2'd3;

  localparam logic PCSEL_INC = 1'b0;
  localparam logic PCSEL_IMM = 1'b1;

  typedef struct packed {
    logic       is_two_byte;
    logic       is_alu;
    logic       is_branch;
    logic       is_halt;
    logic       is_illegal;
    logic       is_write;
    logic [1:0] regsel;
    logic [1:0] addrsel;
    logic [1:0] aluop;
  } decode_t;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control bundle between the sequencer (master) and the datapath (slave).
interface cpu_sequencer_if;
  logic [7:0] irvalue;
  logic       zero;
  logic       negative;
  logic       irload;
  logic       imload;
  logic       pcload;
  logic       pcsel;
  logic [1:0] addrsel;
  logic [1:0] regsel;
  logic       dwrite;
  logic [1:0] dregsel;
  logic [1:0] sregsel;
  logic [1:0] aluop;
  logic       halted;
  logic [2:0] phase;

  modport master (
    input  irvalue, zero, negative,
    output irload, imload, pcload, pcsel, addrsel, regsel, dwrite,
           dregsel, sregsel, aluop, halted, phase
  );

  modport slave (
    output irvalue, zero, negative,
    input  irload, imload, pcload, pcsel, addrsel, regsel, dwrite,
           dregsel, sregsel, aluop, halted, phase
  );
endinterface

// File: rtl/cpu_sequencer_instr_decoder.sv
// Combinational opcode classifier: instruction length, class flags and the
// result-mux / address-mux / ALU codes used when the instruction executes.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output decode_t    dec
);

  // NOTE: every field gets a default before the case so no path can infer a latch.
  always_comb begin
    dec = '0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        dec.is_alu   = 1'b1;
        dec.is_write = 1'b1;
        dec.regsel   = REG_ALU;
        dec.aluop    = opcode[1:0] - 2'd1;
      end
      OP_MOV: begin
        dec.is_write = 1'b1;
        dec.regsel   = REG_SBUS;
      end
      OP_LDI: begin
        dec.is_two_byte = 1'b1;
        dec.is_write    = 1'b1;
        dec.regsel      = REG_IMM;
      end
      OP_LD: begin
        dec.is_write = 1'b1;
        dec.regsel   = REG_DATAIN;
        dec.addrsel  = ADDR_SBUS;
      end
      OP_JMP, OP_JZ, OP_JN: begin
        dec.is_two_byte = 1'b1;
        dec.is_branch   = 1'b1;
      end
      OP_HALT:           dec.is_halt    = 1'b1;
      4'hC, 4'hD, 4'hE:  dec.is_illegal = 1'b1;
      // NOP and the reserved store slot fall through as no-ops
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/Decode/Execute controller: Moore outputs decoded from state and the
// instruction register, driving every strobe and select of the datapath.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter bit ILLEGAL_HALTS = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  cpu_sequencer_if.master bus
);

  logic [2:0] state, state_nxt;
  decode_t    dec;
  logic [3:0] opcode;
  logic       branch_taken;
  logic       enter_halt;

  assign opcode = bus.irvalue[7:4];

  instr_decoder u_decoder (
    .opcode (opcode),
    .dec    (dec)
  );

  // Conditional jumps resolve on the flag as seen during EXEC
  assign branch_taken = (opcode == OP_JMP) ||
                        ((opcode == OP_JZ) && bus.zero) ||
                        ((opcode == OP_JN) && bus.negative);

  assign enter_halt = dec.is_halt || (ILLEGAL_HALTS && dec.is_illegal);

  // NOTE: state is held in a non-blocking flop; the async clear forces RST at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RST;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RST:    state_nxt = ST_FETCH;
      ST_FETCH:  state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (enter_halt)           state_nxt = ST_HALT;
        else if (dec.is_two_byte) state_nxt = ST_IMM;
        else                      state_nxt = ST_EXEC;
      end
      ST_IMM:    state_nxt = ST_EXEC;
      ST_EXEC:   state_nxt = ST_FETCH;
      ST_HALT:   state_nxt = ST_HALT;
      default:   state_nxt = ST_RST;
    endcase
  end

  always_comb begin
    bus.irload  = 1'b0;
    bus.imload  = 1'b0;
    bus.pcload  = 1'b0;
    bus.pcsel   = PCSEL_INC;
    bus.addrsel = ADDR_PC;
    bus.regsel  = REG_IMM;
    bus.dwrite  = 1'b0;
    bus.halted  = 1'b0;
    case (state)
      ST_FETCH: begin
        bus.irload = 1'b1;
        bus.pcload = 1'b1;
      end
      ST_IMM: begin
        bus.imload = 1'b1;
        bus.pcload = 1'b1;
      end
      ST_EXEC: begin
        if (dec.is_write) begin
          bus.dwrite  = 1'b1;
          bus.regsel  = dec.regsel;
          bus.addrsel = dec.addrsel;
        end else if (dec.is_branch && branch_taken) begin
          bus.pcload = 1'b1;
          bus.pcsel  = PCSEL_IMM;
        end
      end
      ST_HALT:  bus.halted = 1'b1;
      default: ;
    endcase
  end

  // Register selects and ALU op track the IR everywhere except reset
  assign bus.dregsel = (state == ST_RST) ? 2'd0 : bus.irvalue[3:2];
  assign bus.sregsel = (state == ST_RST) ? 2'd0 : bus.irvalue[1:0];
  assign bus.aluop   = (state == ST_RST) ? 2'd0 : dec.aluop;
  assign bus.phase   = state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: two instances (illegal-as-NOP and
// illegal-halts) stepped in lockstep through hand-computed instruction cycles.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] ir;
  logic       zero;
  logic       negative;
  int         n_checks;
  int         n_errors;

  cpu_sequencer_if bus0 ();
  cpu_sequencer_if bus1 ();

  assign bus0.irvalue  = ir;
  assign bus0.zero     = zero;
  assign bus0.negative = negative;
  assign bus1.irvalue  = ir;
  assign bus1.zero     = zero;
  assign bus1.negative = negative;

  cpu_sequencer #(.ILLEGAL_HALTS(1'b0)) dut_nop  (.clk(clk), .rst_n(rst_n), .bus(bus0));
  cpu_sequencer #(.ILLEGAL_HALTS(1'b1)) dut_halt (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {phase, irload, imload, pcload, pcsel, addrsel, regsel, dwrite, halted, aluop, dregsel, sregsel}
  logic [18:0] obs0, obs1;
  assign obs0 = {bus0.phase, bus0.irload, bus0.imload, bus0.pcload, bus0.pcsel, bus0.addrsel,
                 bus0.regsel, bus0.dwrite, bus0.halted, bus0.aluop, bus0.dregsel, bus0.sregsel};
  assign obs1 = {bus1.phase, bus1.irload, bus1.imload, bus1.pcload, bus1.pcsel, bus1.addrsel,
                 bus1.regsel, bus1.dwrite, bus1.halted, bus1.aluop, bus1.dregsel, bus1.sregsel};

  function automatic logic [1:0] exp_aluop(logic [7:0] v);
    logic [3:0] op;
    op = v[7:4];
    if (op >= 4'd1 && op <= 4'd4) return 2'(op - 4'd1);
    return 2'd0;
  endfunction

  function automatic logic [18:0] ev(logic [2:0] ph, logic irl, logic iml, logic pcl, logic pcs,
                                     logic [1:0] a, logic [1:0] r, logic dw, logic hl);
    logic [5:0] tail;
    tail = (ph == ST_RST) ? 6'd0 : {exp_aluop(ir), ir[3:2], ir[1:0]};
    return {ph, irl, iml, pcl, pcs, a, r, dw, hl, tail};
  endfunction

  task automatic check(string tag, logic [18:0] got, logic [18:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_fetch(string tag);
    check(tag, obs0, ev(ST_FETCH, 1, 0, 1, 0, 2'd0, 2'd0, 0, 0));
  endtask

  task automatic check_idle(string tag, logic [2:0] ph);
    check(tag, obs0, ev(ph, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    ir       = 8'h00;
    zero     = 1'b0;
    negative = 1'b0;

    repeat (3) step();
    check("reset_nop",  obs0, ev(ST_RST, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0));
    check("reset_halt", obs1, ev(ST_RST, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0));
    rst_n = 1'b1;
    step();
    check_fetch("fetch_first");

    // ADD R1,R2: three clocks FETCH to FETCH
    ir = 8'h16;
    step(); check_idle("add_decode", ST_DECODE);
    step(); check("add_exec", obs0, ev(ST_EXEC, 0, 0, 0, 0, ADDR_PC, REG_ALU, 1, 0));
    step(); check_fetch("add_refetch");

    // OR R2,R1 exercises a non-zero aluop
    ir = 8'h49;
    step(); check_idle("or_decode", ST_DECODE);
    step(); check("or_exec", obs0, ev(ST_EXEC, 0, 0, 0, 0, ADDR_PC, REG_ALU, 1, 0));
    step(); check_fetch("or_refetch");

    // LDI R3: four clocks with an IMM fetch
    ir = 8'h6C;
    step(); check_idle("ldi_decode", ST_DECODE);
    step(); check("ldi_imm",  obs0, ev(ST_IMM, 0, 1, 1, 0, ADDR_PC, REG_IMM, 0, 0));
    step(); check("ldi_exec", obs0, ev(ST_EXEC, 0, 0, 0, 0, ADDR_PC, REG_IMM, 1, 0));
    step(); check_fetch("ldi_refetch");

    // LD R2,[R3]
    ir = 8'h7B;
    step(); check_idle("ld_decode", ST_DECODE);
    step(); check("ld_exec", obs0, ev(ST_EXEC, 0, 0, 0, 0, ADDR_SBUS, REG_DATAIN, 1, 0));
    step(); check_fetch("ld_refetch");

    // JZ taken
    ir = 8'hA0; zero = 1'b1;
    step(); step();
    check("jz_imm", obs0, ev(ST_IMM, 0, 1, 1, 0, ADDR_PC, REG_IMM, 0, 0));
    step(); check("jz_taken", obs0, ev(ST_EXEC, 0, 0, 1, 1, ADDR_PC, REG_IMM, 0, 0));
    step(); check_fetch("jz_taken_refetch");

    // JZ not taken
    zero = 1'b0;
    step(); step(); step();
    check_idle("jz_not_taken", ST_EXEC);
    step(); check_fetch("jz_nt_refetch");

    // JN taken on negative
    ir = 8'hB0; negative = 1'b1;
    step(); step(); step();
    check("jn_taken", obs0, ev(ST_EXEC, 0, 0, 1, 1, ADDR_PC, REG_IMM, 0, 0));
    negative = 1'b0;
    step(); check_fetch("jn_refetch");

    // Illegal 0xD0: NOP on one instance, HALT on the other
    ir = 8'hD0;
    step(); check_idle("ill_decode", ST_DECODE);
    step();
    check_idle("ill_exec_nop", ST_EXEC);
    check("ill_halts", obs1, ev(ST_HALT, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1));
    step(); check_fetch("ill_refetch");

    // HALT holds for 20 clocks with no strobes
    ir = 8'hF0;
    step(); check_idle("halt_decode", ST_DECODE);
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("halt_hold_%0d", i), obs0, ev(ST_HALT, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1));
    end
    check("halt_other", obs1, ev(ST_HALT, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1));

    #1 rst_n = 1'b0;
    #1 check("halt_reset", obs0, ev(ST_RST, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0));
    @(negedge clk) rst_n = 1'b1;
    ir = 8'h16;
    step();
    check_fetch("restart_fetch");
    check("restart_fetch_b", obs1, ev(ST_FETCH, 1, 0, 1, 0, 2'd0, 2'd0, 0, 0));

    // Reset in the middle of EXEC kills the write immediately
    step(); step();
    check("mid_exec", obs0, ev(ST_EXEC, 0, 0, 0, 0, ADDR_PC, REG_ALU, 1, 0));
    #1 rst_n = 1'b0;
    #1 check("mid_exec_abort",   obs0, ev(ST_RST, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0));
    check("mid_exec_abort_b", obs1, ev(ST_RST, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0));
    @(negedge clk) rst_n = 1'b1;
    step();
    check_fetch("final_fetch");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
